ram_multi_read_port: RTL
========================

// Module: ram_multi_read_port
// PURPOSE
//  Parametrised successor to the dual-read-port row RAM. One write port, READ_PORTS independent read ports.
//  Adds per-lane (X/Y/Z) write masking, read enables with valid flags, and optional write-to-read bypass.
//  Adds an optional output register and a self-clearing sweep after reset or on request.
//  Used as the register file and data memory of the execution core; all ports are synchronous to one clock.
// PARAMETERS
//  DATA_WIDTH  96  row width (`DATA_ROW_WIDTH); must be divisible by LANES
//  LANES       3   independently writable lanes per row; LANE_W = DATA_WIDTH/LANES
//  ADDR_WIDTH  7   address width (`DATA_ADDRESS_WIDTH)
//  MEM_SIZE    128 rows implemented; must be <= 2**ADDR_WIDTH
//  READ_PORTS  2   number of read ports, >= 1
//  OUT_REG     0   1 = extra output register stage (read latency 2 instead of 1)
//  BYPASS      1   1 = same-cycle write is forwarded to matching reads
// PORTS
//  Clock           in   1                      single clock, rising edge
//  Reset           in   1                      synchronous, active-high
//  iClear          in   1                      pulse: start zero sweep (accepted only when not busy)
//  iWriteEnable    in   1                      write strobe
//  iWriteLaneMask  in   LANES                  bit k enables lane k (bits [k*LANE_W +: LANE_W])
//  iWriteAddress   in   ADDR_WIDTH             write row
//  iDataIn         in   DATA_WIDTH             write data
//  iReadEnable     in   READ_PORTS             per-port read strobe
//  iReadAddress    in   READ_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  oDataOut        out  READ_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//  oDataValid      out  READ_PORTS             per-port data-valid flag
//  oBusy           out  1                      clear sweep in progress
// BEHAVIOUR
//  Reset (sync, active-high): oDataOut=0, oDataValid=0, oBusy=1, state=CLEAR, sweep counter=0, pipeline regs=0.
//  FSM CLEAR: each non-reset cycle writes 0 to Ram[cnt], then cnt++.
//   After writing row MEM_SIZE-1, go to READY; oBusy is 1 for exactly MEM_SIZE cycles after Reset falls.
//  FSM READY: iClear=1 -> CLEAR with cnt=0 (oBusy=1 from the next cycle).
//   iClear while busy is ignored; Reset in any state restarts the sweep from row 0.
//  While busy: user writes dropped, iReadEnable ignored, oDataValid=0, oDataOut holds.
//  Write (READY): iWriteEnable=1 and iWriteAddress<MEM_SIZE -> lanes with mask bit set updated at the edge.
//   Masked-off lanes are untouched. Mask 0 = no-op. Address >= MEM_SIZE: write dropped.
//  Read (READY, OUT_REG=0): iReadEnable[p] at edge N -> oDataOut[p] and oDataValid[p]=1 after edge N.
//   iReadEnable[p]=0 -> oDataValid[p]=0 next cycle, oDataOut[p] holds.
//  OUT_REG=1: data and valid delayed by one more register; latency 2; throughput 1 read/port/cycle.
//  Read address >= MEM_SIZE: returns 0 with valid=1.
//  Read/write same row same cycle:
//   BYPASS=1 -> enabled lanes return iDataIn, others return stored data (merged row).
//   BYPASS=0 -> old stored row returned.
//  Multiple ports may read the same row in one cycle; all return identical data.
//  Reset mid-read: pending OUT_REG stage flushed (valid=0); no stale valid after reset.
// STRUCTURE
//  aDefinitions.v gains `RAM_LANES (3) and the FSM state encodings `RAM_ST_CLEAR / `RAM_ST_READY.
//  It keeps `DATA_ROW_WIDTH / `DATA_ADDRESS_WIDTH as the parameter defaults.
//  One sub-module: ram_clear_sequencer (counter + FSM, outputs oBusy, clear address, clear write strobe).
//  Write-port mux in top: clear sweep has priority over the user port.
//  Per-port read/bypass/pipeline logic in a generate loop over READ_PORTS; no per-port sub-module.
// TESTING
//  1 Reset 3 cycles, release -> oBusy=1 for 128 cycles then 0; read rows 0,127 -> 0 with valid=1, latency 1.
//  2 Write row 5 = 0x..AAAA_BBBB_CCCC, mask 3'b010, prior row 0 -> read row 5 returns lane1 only,
//    lanes 0/2 = 0.
//  3 Same cycle: write row 9 mask 3'b111 data D, port0 and port1 read row 9.
//    BYPASS=1 -> both return D; BYPASS=0 -> both return old value.
//  4 OUT_REG=1, back-to-back reads rows 1,2,3 on port0 -> data valid on cycles N+2..N+4,
//    one row per cycle, in order.
//  5 Fill rows, pulse iClear -> oBusy 128 cycles.
//    Writes during sweep are dropped; afterwards all rows read 0. iClear while busy has no effect.
//  6 Assert Reset mid-sweep (cnt=60) and mid-read -> valid drops to 0.
//    Sweep restarts from 0 and lasts a full 128 cycles.

Source files
------------

// File: rtl/ram_multi_read_port_pkg.sv
// Shared definitions for the multi-read-port row RAM.
// Row geometry defaults and clear-sequencer state encodings.
package ram_multi_read_port_pkg;

    localparam int DATA_ROW_WIDTH     = 96;
    localparam int DATA_ADDRESS_WIDTH = 7;
    localparam int RAM_LANES          = 3;

    typedef enum logic {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_multi_read_port_clear_sequencer.sv
// Zero-sweep sequencer: walks every row once after reset or on request.
// Busy for exactly MEM_SIZE cycles; requests while busy are ignored.
module ram_clear_sequencer
    import ram_multi_read_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
    parameter int MEM_SIZE   = 128
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iClear,
    output logic                  oBusy,
    output logic [ADDR_WIDTH-1:0] oClearAddress,
    output logic                  oClearWrite
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_SIZE - 1);

    ram_state_e            state;
    ram_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nxt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RAM_ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RAM_ST_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RAM_ST_READY;
                    cnt_nxt   = '0;
                end
            end
            RAM_ST_READY: begin
                if (iClear) begin
                    state_nxt = RAM_ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign oBusy         = (state == RAM_ST_CLEAR);
    assign oClearWrite   = (state == RAM_ST_CLEAR) && !Reset;
    assign oClearAddress = cnt;

endmodule

// File: rtl/ram_multi_read_port.sv
// Row RAM with one lane-masked write port and READ_PORTS read ports.
// Optional write-to-read bypass, optional output register, zero sweep.
module ram_multi_read_port
    import ram_multi_read_port_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_ROW_WIDTH,
    parameter int LANES      = RAM_LANES,
    parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
    parameter int MEM_SIZE   = 128,
    parameter int READ_PORTS = 2,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             iClear,
    input  logic                             iWriteEnable,
    input  logic [LANES-1:0]                 iWriteLaneMask,
    input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
    input  logic [DATA_WIDTH-1:0]            iDataIn,
    input  logic [READ_PORTS-1:0]            iReadEnable,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
    output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
    output logic [READ_PORTS-1:0]            oDataValid,
    output logic                             oBusy
);

    localparam int LANE_W = DATA_WIDTH / LANES;

    logic [DATA_WIDTH-1:0] ram [MEM_SIZE];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_user;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH + 1)'(MEM_SIZE);
    endfunction

    ram_clear_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_SIZE  (MEM_SIZE)
    ) u_clear (
        .Clock        (Clock),
        .Reset        (Reset),
        .iClear       (iClear),
        .oBusy        (busy),
        .oClearAddress(clr_addr),
        .oClearWrite  (clr_we)
    );

    assign oBusy   = busy;
    assign wr_user = !Reset && !busy && iWriteEnable
                     && in_range(iWriteAddress);

    // The sweep owns the write port while it runs.
    always_ff @(posedge Clock) begin
        if (clr_we) begin
            ram[clr_addr] <= '0;
        end else if (wr_user) begin
            for (int k = 0; k < LANES; k++) begin
                if (iWriteLaneMask[k]) begin
                    ram[iWriteAddress][k*LANE_W +: LANE_W] <=
                        iDataIn[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] stored;
        logic [DATA_WIDTH-1:0] rdata;
        logic [DATA_WIDTH-1:0] d1;
        logic                  v1;

        assign raddr = iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            stored = '0;
            if (in_range(raddr)) begin
                stored = ram[raddr];
            end
            rdata = stored;
            if (BYPASS != 0 && wr_user && iWriteAddress == raddr) begin
                for (int k = 0; k < LANES; k++) begin
                    if (iWriteLaneMask[k]) begin
                        rdata[k*LANE_W +: LANE_W] =
                            iDataIn[k*LANE_W +: LANE_W];
                    end
                end
            end
        end

        always_ff @(posedge Clock) begin
            if (Reset) begin
                d1 <= '0;
                v1 <= 1'b0;
            end else if (!busy && iReadEnable[p]) begin
                d1 <= rdata;
                v1 <= 1'b1;
            end else begin
                v1 <= 1'b0;
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] d2;
            logic                  v2;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1 && !busy;
                    if (v1 && !busy) begin
                        d2 <= d1;
                    end
                end
            end

            assign oDataOut[p*DATA_WIDTH +: DATA_WIDTH] = d2;
            assign oDataValid[p]                        = v2;
        end else begin : g_direct
            assign oDataOut[p*DATA_WIDTH +: DATA_WIDTH] = d1;
            assign oDataValid[p]                        = v1;
        end
    end

endmodule
